// File: rtl/my_iterative_shifter.sv
// Multi-cycle barrel shifter: SLL/SRL/SRA/ROL, applying STAGES_PER_CYCLE binary
// stages per clock so latency depends only on parameters, never on shamt.
module my_iterative_shifter #(
  parameter int WIDTH            = 32,
  parameter int SHAMT_W          = 5,
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  localparam int IDX_W = $clog2(SHAMT_W + STAGES_PER_CYCLE + 1);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         mode_q, mode_d;
  logic               sign_q, sign_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   shifted;

  // One binary stage of 2^k; fill is the captured operand MSB for SRA.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] v,
                                                   input int k,
                                                   input logic [1:0] m,
                                                   input logic fill);
    int amt;
    logic [WIDTH-1:0] r;
    amt = 1 << k;
    case (m)
      MODE_SLL: r = v << amt;
      MODE_SRL: r = v >> amt;
      MODE_SRA: r = (v >> amt) | (fill ? ~({WIDTH{1'b1}} >> amt) : '0);
      default:  r = (v << amt) | (v >> (WIDTH - amt));
    endcase
    return r;
  endfunction

  always_comb begin
    shifted = work_q;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (int'(idx_q) <= k && k < int'(idx_q) + STAGES_PER_CYCLE && shamt_q[k])
        shifted = shift_stage(shifted, k, mode_q, sign_q);
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_in;
          shamt_d = shamt;
          mode_d  = mode;
          sign_d  = data_in[WIDTH-1];
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      default: begin
        work_d = shifted;
        idx_d  = idx_q + IDX_W'(STAGES_PER_CYCLE);
        // Last (possibly partial) group retires the result.
        if (int'(idx_q) + STAGES_PER_CYCLE >= SHAMT_W) begin
          dout_d  = shifted;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      idx_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_my_iterative_shifter.sv
// Scoreboard bench for my_iterative_shifter: default 32-bit instance plus a
// 16-bit / 3-stages-per-cycle instance, both checked against a plain-arithmetic model.
module tb_my_iterative_shifter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        start_a [2];
  logic [31:0] din_a   [2];
  logic [4:0]  sh_a    [2];
  logic [1:0]  md_a    [2];

  logic        busy0, done0, busy1, done1;
  logic [31:0] dout0;
  logic [15:0] dout1;

  my_iterative_shifter dut0 (
    .clock(clock), .reset(reset), .start(start_a[0]), .data_in(din_a[0]),
    .shamt(sh_a[0]), .mode(md_a[0]), .busy(busy0), .done(done0), .data_out(dout0)
  );

  my_iterative_shifter #(.WIDTH(16), .SHAMT_W(4), .STAGES_PER_CYCLE(3)) dut1 (
    .clock(clock), .reset(reset), .start(start_a[1]), .data_in(din_a[1][15:0]),
    .shamt(sh_a[1][3:0]), .mode(md_a[1]), .busy(busy1), .done(done1), .data_out(dout1)
  );

  typedef struct {
    int          dut;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          nl[2] = '{5, 2};
  int          wd[2] = '{32, 16};
  int          acc[2];
  int          next_ok[2];
  logic [31:0] last_out[2];
  int          tests = 0;
  int          fails = 0;

  always @(posedge clock) cyc++;

  function automatic logic [31:0] ref_model(input logic [31:0] d, input int s,
                                            input logic [1:0] m, input int w);
    logic [63:0] mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    case (m)
      2'b00: r = (x << s) & mask;
      2'b01: r = x >> s;
      2'b10: begin
        r = x >> s;
        if (x[w-1]) r = r | (mask & ~(mask >> s));
      end
      default: r = ((x << s) | (x >> (w - s))) & mask;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int i);
    logic        b, d;
    logic [31:0] o;
    logic        exp_busy;
    int          idx;
    b = (i == 0) ? busy0 : busy1;
    d = (i == 0) ? done0 : done1;
    o = (i == 0) ? dout0 : {16'd0, dout1};
    exp_busy = (cyc >= acc[i]) && (cyc < acc[i] + nl[i]);
    chk($sformatf("busy%0d", i), {31'd0, b}, {31'd0, exp_busy});
    idx = -1;
    foreach (sb[j]) if (sb[j].dut == i && idx < 0) idx = j;
    if (d) begin
      if (idx < 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done%0d: got done=1 data %h expected no done (t=%0t)", i, o, $time);
      end else begin
        chk($sformatf("result%0d", i), o, sb[idx].val);
        chk($sformatf("latency%0d", i), cyc, sb[idx].cyc);
        last_out[i] = sb[idx].val;
        sb.delete(idx);
      end
    end else begin
      chk($sformatf("hold%0d", i), o, last_out[i]);
      if (idx >= 0 && sb[idx].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_done%0d: got no done at cycle %0d expected done with %h", i, sb[idx].cyc, sb[idx].val);
        sb.delete(idx);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      acc[i]      = -1000;
      next_ok[i]  = 0;
      last_out[i] = '0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy0"}, {31'd0, busy0}, 32'd0);
    chk({tag, "_done0"}, {31'd0, done0}, 32'd0);
    chk({tag, "_dout0"}, dout0, 32'd0);
    chk({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
    chk({tag, "_done1"}, {31'd0, done1}, 32'd0);
    chk({tag, "_dout1"}, {16'd0, dout1}, 32'd0);
  endtask

  // Callers sit just after a falling edge.
  task automatic idle(input int n);
    repeat (n) begin
      for (int i = 0; i < 2; i++) begin
        start_a[i] = 1'b0;
        din_a[i]   = $urandom;
        sh_a[i]    = 5'($urandom);
        md_a[i]    = 2'($urandom);
      end
      @(negedge clock);
    end
  endtask

  task automatic issue(input int i, input logic [31:0] d, input int s, input logic [1:0] m);
    int e;
    start_a[i] = 1'b1;
    din_a[i]   = d;
    sh_a[i]    = 5'(s);
    md_a[i]    = m;
    e = cyc + 1;
    if (e >= next_ok[i]) begin
      sb.push_back('{dut: i, val: ref_model(d, s, m, wd[i]), cyc: e + nl[i]});
      acc[i]     = e;
      next_ok[i] = e + nl[i] + 1;
    end
    @(negedge clock);
    start_a[i] = 1'b0;
  endtask

  task automatic run(input int i, input logic [31:0] d, input int s, input logic [1:0] m);
    issue(i, d, s, m);
    idle(nl[i] + 1);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0;
      din_a[i]   = '0;
      sh_a[i]    = '0;
      md_a[i]    = '0;
    end
    model_reset();
    @(negedge clock);
    check_zero("reset");
    @(negedge clock);
    reset = 1'b0;
    idle(3);
    check_zero("idle");

    run(0, 32'h0000_00F1, 4, 2'b00);
    run(0, 32'h8000_0010, 4, 2'b10);
    run(0, 32'h8000_0010, 4, 2'b01);
    run(0, 32'h8000_0001, 1, 2'b11);
    run(0, 32'h0000_0001, 31, 2'b00);
    for (int m = 0; m < 4; m++) run(0, 32'hDEAD_BEEF, 0, 2'(m));

    // Start while busy is dropped.
    issue(0, 32'h1234_5678, 8, 2'b11);
    issue(0, 32'hFFFF_0000, 3, 2'b01);
    idle(nl[0] + 1);

    // Start during the done cycle is accepted.
    issue(0, 32'h0000_00FF, 2, 2'b00);
    idle(nl[0]);
    issue(0, 32'hF000_0000, 7, 2'b10);
    idle(nl[0] + 1);

    // Reset two cycles into an operation.
    issue(0, 32'hCAFE_F00D, 5, 2'b00);
    idle(1);
    reset = 1'b1;
    model_reset();
    #1;
    check_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    idle(nl[0] + 2);
    run(0, 32'h0F0F_0F0F, 12, 2'b11);

    run(1, 32'h0000_8010, 4, 2'b10);
    run(1, 32'h0000_8001, 15, 2'b11);
    run(1, 32'h0000_BEEF, 0, 2'b01);

    for (int n = 0; n < 150; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      issue(i, $urandom, int'($urandom_range(0, wd[i] - 1)), 2'($urandom));
      idle(int'($urandom_range(0, nl[i] + 1)));
    end

    idle(12);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
